// File: rtl/snow64_mem_req_scheduler.sv
// Round-robin arbiter sharing the memory bus guard between instruction fetch, LAR reads and LAR writes.
// One guard transaction in flight: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT timeout and sticky error flags.
module snow64_mem_req_scheduler #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_done,
  output logic [DATA_WIDTH-1:0] instr_data,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_done,
  output logic                  g_rd_instr_req,
  output logic                  g_rd_data_req,
  output logic                  g_wr_data_req,
  output logic [ADDR_WIDTH-1:0] g_addr,
  output logic [DATA_WIDTH-1:0] g_wdata,
  input  logic                  g_rd_instr_valid,
  input  logic                  g_rd_data_valid,
  input  logic                  g_wr_data_valid,
  input  logic [DATA_WIDTH-1:0] g_rdata,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic                  timeout_err,
  output logic                  protocol_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic [1:0]            rr_ptr;
  logic [CW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [2:0] req_vec;
  logic [2:0] valid_vec;
  logic [2:0] active_oh;
  logic       match_vld;
  logic       stray_vld;
  logic [1:0] c0, c1, c2;
  logic [1:0] pick_id;
  logic       pick_vld;

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  assign req_vec   = {wr_req, rd_req, instr_req};
  assign valid_vec = {g_wr_data_valid, g_rd_data_valid, g_rd_instr_valid};
  assign active_oh = 3'b001 << grant_id;
  assign match_vld = |(valid_vec & active_oh);
  assign stray_vld = |(valid_vec & ~active_oh);

  // Search order starts just after the last granted requester.
  assign c0 = rr_next(rr_ptr);
  assign c1 = rr_next(c0);
  assign c2 = rr_next(c1);

  always_comb begin
    pick_vld = 1'b1;
    pick_id  = c0;
    if (req_vec[c0])      pick_id = c0;
    else if (req_vec[c1]) pick_id = c1;
    else if (req_vec[c2]) pick_id = c2;
    else                  pick_vld = 1'b0;
  end

  assign instr_data = rdata_q;
  assign rd_data    = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= 2'd2;
      wait_cnt       <= '0;
      rdata_q        <= '0;
      instr_done     <= 1'b0;
      rd_done        <= 1'b0;
      wr_done        <= 1'b0;
      g_rd_instr_req <= 1'b0;
      g_rd_data_req  <= 1'b0;
      g_wr_data_req  <= 1'b0;
      g_addr         <= '0;
      g_wdata        <= '0;
      busy           <= 1'b0;
      grant_id       <= 2'd0;
      timeout_err    <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      instr_done     <= 1'b0;
      rd_done        <= 1'b0;
      wr_done        <= 1'b0;
      g_rd_instr_req <= 1'b0;
      g_rd_data_req  <= 1'b0;
      g_wr_data_req  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_id <= pick_id;
            rr_ptr   <= pick_id;
            busy     <= 1'b1;
            wait_cnt <= '0;
            {g_wr_data_req, g_rd_data_req, g_rd_instr_req} <= 3'b001 << pick_id;
            case (pick_id)
              2'd0:    g_addr <= instr_addr;
              2'd1:    g_addr <= rd_addr;
              default: begin
                g_addr  <= wr_addr;
                g_wdata <= wr_data;
              end
            endcase
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (stray_vld) protocol_err <= 1'b1;
          if (match_vld) begin
            rdata_q <= (grant_id == 2'd2) ? '0 : g_rdata;
            {wr_done, rd_done, instr_done} <= active_oh;
            state <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            rdata_q     <= '0;
            {wr_done, rd_done, instr_done} <= active_oh;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          // RESP always returns to IDLE so a held request is re-arbitrated, never re-counted.
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_mem_req_scheduler.sv
// Self-checking bench: fixed-latency guard model, vector table of single transactions,
// scoreboard of expected completions, plus round-robin, timeout, protocol-error and reset sequences.
module tb_snow64_mem_req_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         instr_req = 1'b0;
  logic [63:0]  instr_addr = '0;
  logic         instr_done;
  logic [255:0] instr_data;
  logic         rd_req = 1'b0;
  logic [63:0]  rd_addr = '0;
  logic         rd_done;
  logic [255:0] rd_data;
  logic         wr_req = 1'b0;
  logic [63:0]  wr_addr = '0;
  logic [255:0] wr_data = '0;
  logic         wr_done;
  logic         g_rd_instr_req, g_rd_data_req, g_wr_data_req;
  logic [63:0]  g_addr;
  logic [255:0] g_wdata;
  logic         g_rd_instr_valid, g_rd_data_valid, g_wr_data_valid;
  logic [255:0] g_rdata = '0;
  logic         busy;
  logic [1:0]   grant_id;
  logic         timeout_err, protocol_err;

  always #5 clk = ~clk;

  snow64_mem_req_scheduler #(.ADDR_WIDTH(64), .DATA_WIDTH(256), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_done(instr_done), .instr_data(instr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .g_rd_instr_req(g_rd_instr_req), .g_rd_data_req(g_rd_data_req), .g_wr_data_req(g_wr_data_req),
    .g_addr(g_addr), .g_wdata(g_wdata),
    .g_rd_instr_valid(g_rd_instr_valid), .g_rd_data_valid(g_rd_data_valid),
    .g_wr_data_valid(g_wr_data_valid), .g_rdata(g_rdata),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .protocol_err(protocol_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Guard model: valid three cycles after the request cycle, optionally muted or preceded by a stray valid.
  logic [2:0]   gv = '0;
  logic [255:0] guard_data = '0;
  bit           guard_mute = 0;
  bit           guard_wrong = 0;
  int           gk;
  assign {g_wr_data_valid, g_rd_data_valid, g_rd_instr_valid} = gv;

  always begin
    @(posedge clk); #1;
    if (g_rd_instr_req || g_rd_data_req || g_wr_data_req) begin
      gk = g_rd_instr_req ? 0 : (g_rd_data_req ? 1 : 2);
      if (guard_wrong) begin
        @(posedge clk); #1; gv = 3'b001 << ((gk == 1) ? 0 : 1);
        @(posedge clk); #1; gv = '0;
        @(posedge clk); #1;
      end else begin
        repeat (3) @(posedge clk);
        #1;
      end
      if (!guard_mute) begin
        gv = 3'b001 << gk;
        g_rdata = guard_data;
        @(posedge clk); #1;
        gv = '0;
      end
    end
  end

  // Scoreboard of expected completions, popped whenever a done pulse appears.
  typedef struct { logic [1:0] who; logic [255:0] data; } exp_t;
  exp_t sb[$];
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (instr_done | rd_done | wr_done) begin
        exp_t e;
        chk("single_pulse", prev_done, 0);
        chk("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("done_id", {wr_done, rd_done, instr_done}, 3'b001 << e.who);
          if (e.who == 2'd0) chk("instr_data", instr_data, e.data);
          if (e.who == 2'd1) chk("rd_data", rd_data, e.data);
        end
      end
      prev_done = instr_done | rd_done | wr_done;
    end
  end

  task automatic run_txn(input string nm, input logic [1:0] who, input logic [63:0] addr,
                         input logic [255:0] wdat, input logic [255:0] gdat,
                         input logic [255:0] exp_dat, input int exp_lat);
    exp_t e;
    bit got;
    logic [2:0] oh;
    oh = 3'b001 << who;
    @(posedge clk); #1;
    guard_data = gdat;
    case (who)
      2'd0:    begin instr_addr = addr; instr_req = 1'b1; end
      2'd1:    begin rd_addr = addr; rd_req = 1'b1; end
      default: begin wr_addr = addr; wr_data = wdat; wr_req = 1'b1; end
    endcase
    e.who = who;
    e.data = exp_dat;
    sb.push_back(e);
    got = 0;
    for (int k = 1; k <= exp_lat + 10 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 1 && who == 2'd2) wr_data = ~wdat;
      @(negedge clk);
      if (k == 1) begin
        chk({nm, " g_req"}, {g_wr_data_req, g_rd_data_req, g_rd_instr_req}, oh);
        chk({nm, " g_addr"}, g_addr, addr);
        chk({nm, " grant_id"}, grant_id, who);
        if (who == 2'd2) chk({nm, " g_wdata"}, g_wdata, wdat);
      end
      if (k == 2) chk({nm, " g_req_wait"}, {g_wr_data_req, g_rd_data_req, g_rd_instr_req}, 0);
      if (instr_done | rd_done | wr_done) begin
        got = 1;
        chk({nm, " latency"}, k, exp_lat);
        instr_req = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
    end
    if (!got) chk({nm, " done_seen"}, got, 1);
  endtask

  typedef struct {
    logic [1:0]   who;
    logic [63:0]  addr;
    logic [255:0] wdat;
    logic [255:0] gdat;
    logic [255:0] exp_dat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_c, n_done;
    logic [1:0] exp_rr[6];
    logic [255:0] gpat;

    vecs[0] = '{2'd0, 64'h1000, '0, {32{8'hAA}}, {32{8'hAA}}};
    vecs[1] = '{2'd1, 64'h2000, '0, {32{8'h3C}}, {32{8'h3C}}};
    vecs[2] = '{2'd2, 64'h40, {32{8'h55}}, {32{8'h77}}, '0};
    vecs[3] = '{2'd1, 64'hDEAD_BEEF_0000, '0, {8{32'h0123_4567}}, {8{32'h0123_4567}}};
    vecs[4] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFC0, '0, {16{16'hC0DE}}, {16{16'hC0DE}}};
    exp_rr = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {busy, grant_id, instr_done, rd_done, wr_done,
                     g_rd_instr_req, g_rd_data_req, g_wr_data_req, timeout_err, protocol_err}, 0);
    chk("rst_g_addr", g_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Single transactions from the table
    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].who, vecs[i].addr, vecs[i].wdat,
              vecs[i].gdat, vecs[i].exp_dat, 5);
      @(negedge clk);
    end

    // All three requests held from reset
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    gpat = {4{64'h0BAD_F00D_1234_5678}};
    guard_data = gpat;
    instr_addr = 64'h100; rd_addr = 64'h200; wr_addr = 64'h300; wr_data = {32{8'h11}};
    instr_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.who = exp_rr[i];
      e.data = (exp_rr[i] == 2'd2) ? '0 : gpat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_c = 0;
    n_done = 0;
    for (int c = 1; c <= 60 && n_done < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (instr_done | rd_done | wr_done) begin
        chk($sformatf("rr_grant%0d", n_done), grant_id, exp_rr[n_done]);
        if (n_done > 0) chk($sformatf("rr_spacing%0d", n_done), c - last_c, 6);
        last_c = c;
        n_done++;
        if (n_done == 6) begin
          instr_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        end
      end
    end
    chk("rr_done_count", n_done, 6);
    repeat (3) @(negedge clk);
    chk("rr_idle", busy, 0);

    // Guard never answers: timeout after 64 WAIT cycles, then normal service resumes
    guard_mute = 1;
    run_txn("timeout", 2'd1, 64'h80, '0, {32{8'hEE}}, '0, 66);
    chk("timeout_err_set", timeout_err, 1);
    guard_mute = 0;
    @(negedge clk);
    run_txn("after_timeout", 2'd0, 64'hC0, '0, {32{8'h99}}, {32{8'h99}}, 5);
    chk("timeout_err_sticky", timeout_err, 1);

    // Stray read-data valid during an instruction fetch
    @(negedge clk);
    chk("protocol_err_pre", protocol_err, 0);
    guard_wrong = 1;
    run_txn("protocol", 2'd0, 64'h1040, '0, {32{8'h5A}}, {32{8'h5A}}, 5);
    chk("protocol_err_set", protocol_err, 1);
    guard_wrong = 0;

    // Reset while waiting on the guard; the late valid must be ignored
    @(negedge clk);
    @(posedge clk); #1;
    rd_addr = 64'h5000;
    rd_req = 1'b1;
    guard_data = {32{8'h42}};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rd_req = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_wait_ctrl", {busy, grant_id, instr_done, rd_done, wr_done,
                          g_rd_instr_req, g_rd_data_req, g_wr_data_req, timeout_err, protocol_err}, 0);
    chk("rst_wait_g_addr", g_addr, 0);
    chk("rst_wait_data", rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (instr_done | rd_done | wr_done) n_done++;
    end
    chk("late_valid_no_done", n_done, 0);
    chk("late_valid_no_err", protocol_err, 0);
    chk("late_valid_idle", busy, 0);
    run_txn("after_rst", 2'd2, 64'h6000, {32{8'hA5}}, '0, '0, 5);

    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
